// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: word width, reset
// address, fetch increment and the output-register source selector.
`ifndef FETCH_UNIT_DEFINES
`define FETCH_UNIT_DEFINES
`define WORD_WIDTH 32
`define RESET_PC   32'h0000_0000
`define FETCH_INC  4
`endif

package fetch_unit_pkg;

    // Byte distance between consecutive instruction words.
    localparam int unsigned FETCH_INC = `FETCH_INC;

    // Where the output register takes its next contents from.
    typedef enum logic [1:0] {
        SRC_HOLD  = 2'd0,  // keep current contents
        SRC_SKID  = 2'd1,  // refill from the skid buffer
        SRC_RESP  = 2'd2,  // load the memory response arriving this cycle
        SRC_CLEAR = 2'd3   // nothing to present: drop if_valid
    } out_sel_e;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding an instruction word and its address while
// decode is stalled. Flush wins over load, load wins over drain.
module fetch_skid
    import fetch_unit_pkg::*;
#(
    parameter int W = `WORD_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         load,
    input  logic         drain,
    input  logic [W-1:0] in_data,
    input  logic [W-1:0] in_pc,
    output logic         valid,
    output logic [W-1:0] data,
    output logic [W-1:0] pc
);

    logic         valid_r;
    logic [W-1:0] data_r;
    logic [W-1:0] pc_r;

    // Buffer occupancy and contents; async reset empties it immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= 1'b0;
            data_r  <= '0;
            pc_r    <= '0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= in_data;
            pc_r    <= in_pc;
        end else if (drain) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign valid = valid_r;
    assign data  = data_r;
    assign pc    = pc_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one word address per cycle to a
// synchronous-read instruction memory, tracks the single in-flight request,
// and presents fetched words to decode through a registered output backed by
// a one-entry skid buffer. A branch redirect flushes everything in flight.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int           W        = `WORD_WIDTH,
    parameter logic [W-1:0] RESET_PC = `RESET_PC
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] imem_addr,
    input  logic [W-1:0] imem_data,
    input  logic         br_taken,
    input  logic [W-1:0] br_target,
    input  logic         id_ready,
    output logic         if_valid,
    output logic [W-1:0] if_inst,
    output logic [W-1:0] if_pc
);

    localparam logic [W-1:0] ALIGN_MASK = ~{{(W-2){1'b0}}, 2'b11};
    localparam logic [W-1:0] START_PC   = RESET_PC & ALIGN_MASK;
    localparam logic [W-1:0] PC_STEP    = W'(FETCH_INC);

    logic [W-1:0] fetch_pc_r;
    logic         inflight_r;
    logic [W-1:0] inflight_pc_r;
    logic         if_valid_r;
    logic [W-1:0] if_inst_r;
    logic [W-1:0] if_pc_r;

    logic         skid_valid_s;
    logic [W-1:0] skid_data_s;
    logic [W-1:0] skid_pc_s;

    logic         xfer_s;
    logic         skid_load_s;
    logic         skid_drain_s;
    logic         issue_s;
    logic [W-1:0] target_s;
    logic [W-1:0] fetch_pc_nxt_s;
    out_sel_e     out_sel_s;

    assign imem_addr = fetch_pc_r;
    assign target_s  = br_target & ALIGN_MASK;
    assign xfer_s    = if_valid_r && id_ready;

    // Steering: who fills the output register, when the skid buffer loads or
    // drains, and whether a new request may be issued this cycle.
    always_comb begin
        out_sel_s      = SRC_HOLD;
        skid_load_s    = 1'b0;
        skid_drain_s   = 1'b0;
        issue_s        = 1'b0;
        fetch_pc_nxt_s = fetch_pc_r;
        if (br_taken) begin
            out_sel_s      = SRC_CLEAR;
            fetch_pc_nxt_s = target_s;
        end else begin
            if (xfer_s) begin
                if (skid_valid_s) begin
                    out_sel_s    = SRC_SKID;
                    skid_drain_s = 1'b1;
                end else if (inflight_r) begin
                    out_sel_s = SRC_RESP;
                end else begin
                    out_sel_s = SRC_CLEAR;
                end
            end else if (!if_valid_r && inflight_r) begin
                out_sel_s = SRC_RESP;
            end else if (if_valid_r && inflight_r) begin
                // Decode is stalled and a word is arriving: park it.
                skid_load_s = 1'b1;
            end else begin
                out_sel_s = SRC_HOLD;
            end
            // A full (or filling) skid buffer means one more word would have
            // nowhere to go, so stop issuing until it drains.
            issue_s = !skid_valid_s && !skid_load_s;
            if (issue_s) begin
                fetch_pc_nxt_s = fetch_pc_r + PC_STEP;
            end else begin
                fetch_pc_nxt_s = fetch_pc_r;
            end
        end
    end

    // Fetch address and in-flight request tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_r    <= START_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= '0;
        end else begin
            fetch_pc_r    <= fetch_pc_nxt_s;
            inflight_r    <= issue_s;
            inflight_pc_r <= fetch_pc_r;
        end
    end

    // Output register presented to decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_valid_r <= 1'b0;
            if_inst_r  <= '0;
            if_pc_r    <= '0;
        end else begin
            case (out_sel_s)
                SRC_SKID: begin
                    if_valid_r <= 1'b1;
                    if_inst_r  <= skid_data_s;
                    if_pc_r    <= skid_pc_s;
                end
                SRC_RESP: begin
                    if_valid_r <= 1'b1;
                    if_inst_r  <= imem_data;
                    if_pc_r    <= inflight_pc_r;
                end
                SRC_CLEAR: begin
                    if_valid_r <= 1'b0;
                end
                default: begin
                    if_valid_r <= if_valid_r;
                end
            endcase
        end
    end

    fetch_skid #(
        .W (W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .flush   (br_taken),
        .load    (skid_load_s),
        .drain   (skid_drain_s),
        .in_data (imem_data),
        .in_pc   (inflight_pc_r),
        .valid   (skid_valid_s),
        .data    (skid_data_s),
        .pc      (skid_pc_s)
    );

    assign if_valid = if_valid_r;
    assign if_inst  = if_inst_r;
    assign if_pc    = if_pc_r;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter W, default `WORD_WIDTH (32): address/instruction width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port imem_addr  output  W  byte address to the instruction memory; word-aligned, bits [1:0] always 0.
REQ-006 SHALL have port imem_data  input  W  memory read data, valid the cycle after imem_addr is presented (synchronous read, 1-cycle latency).
REQ-007 SHALL have port br_taken  input  1  redirect request from the execute stage.
REQ-008 SHALL have port br_target  input  W  redirect address; bits [1:0] ignored and treated as 0.
REQ-009 SHALL have port id_ready  input  1  decode can accept an instruction this cycle.
REQ-010 SHALL have port if_valid  output  1  if_inst/if_pc hold a valid instruction.
REQ-011 SHALL have port if_inst  output  W  fetched instruction word.
REQ-012 SHALL have port if_pc  output  W  address of if_inst.

Function
REQ-013 SHALL hold fetch_pc (register) and drive imem_addr = fetch_pc combinationally.
REQ-014 SHALL track one in-flight request (flag + inflight_pc): set when an address is issued and not stalled, cleared otherwise.
REQ-015 SHALL, when the in-flight response arrives, load it into the output register if (!if_valid || id_ready), else into a 1-entry skid buffer.
REQ-016 SHALL, on transfer (if_valid && id_ready), refill the output register from the skid buffer when full, otherwise from the arriving response, otherwise clear if_valid.
REQ-017 SHALL advance fetch_pc by 4 and issue a new request each cycle unless the skid buffer is full, or becomes full this cycle; while stalled fetch_pc holds and no request is in flight.
REQ-018 SHALL sustain 1 instruction/cycle with id_ready held high; first if_valid SHALL assert on the 2nd posedge after rst deasserts.
REQ-019 SHALL, on br_taken, at the same posedge: fetch_pc <= {br_target[W-1:2],2'b00}, drop the in-flight request, clear the skid buffer and if_valid; the response arriving the next cycle SHALL be discarded, and if_valid for the target SHALL assert 2 cycles after the redirect edge.
REQ-020 SHALL give br_taken priority over stall, transfer and skid refill when these occur in the same cycle.
REQ-021 SHALL keep if_inst/if_pc stable while if_valid && !id_ready.
REQ-022 SHALL wrap fetch_pc modulo 2^W (32'hFFFF_FFFC + 4 = 0) without error.
REQ-023 SHALL never deliver an instruction twice or skip one absent a redirect.

Reset
REQ-024 SHALL, while rst is low: fetch_pc = RESET_PC, in-flight flag 0, skid empty, if_valid 0, if_inst 0, if_pc 0.
REQ-025 SHALL, on rst asserted mid-operation, clear all state immediately (asynchronous), discarding any in-flight or buffered instruction.
REQ-026 SHALL issue RESET_PC on the first cycle after rst deasserts.

Structure
REQ-027 SHALL take WORD_WIDTH from defines.v; a RESET_PC default macro and the fetch increment (4) SHALL be added to defines.v.
REQ-028 SHALL isolate the 1-entry skid buffer as sub-module fetch_skid (data+pc, valid, load, drain, flush).
REQ-029 SHALL contain no memory array; the instruction memory remains external.

Verification
REQ-030 SHALL check: reset release, mem word i = 0x1000_0000+i, id_ready=1 -> if_valid at 2nd edge, if_pc 0,4,8,... with if_inst 0x1000_0000,+1,+2 on consecutive cycles.
REQ-031 SHALL check: id_ready low for 3 cycles mid-stream -> if_inst/if_pc frozen, skid fills, no loss/duplication; stream resumes in order at the next pc.
REQ-032 SHALL check: br_taken with br_target 0x0000_0043 while stalled and skid full -> next valid if_pc 0x40, 2 cycles after redirect, no stale instruction delivered.
REQ-033 SHALL check: br_taken on consecutive cycles (targets 0x20 then 0x80) -> only 0x80 stream appears.
REQ-034 SHALL check: rst pulsed low between clock edges mid-stream -> outputs clear immediately; after release, fetch restarts at RESET_PC.
REQ-035 SHALL check: RESET_PC=32'hFFFF_FFF8 -> if_pc FFFF_FFF8, FFFF_FFFC, 0000_0000 in order.
